bcd_updown_counter: RTL
=======================

Name: bcd_updown_counter

Overview:
- Parametrised multi-digit modulo-N up/down counter; the successor to the team's single-digit mod-10 counter.
- Adds runtime direction, synchronous clear, parallel load with range checking, and count-enable.
- Provides a terminal-count output so instances can cascade, plus registered overflow/underflow pulses.
- Drives display/timebase logic, e.g. seven-segment scanners and stopwatch blocks.

Parameters:
- DIGITS, 4, number of cascaded digits (1..8).
- MODULUS, 10, count base of every digit (2..16); each digit counts 0..MODULUS-1.
- DW, 4, bits per digit; fixed localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- clear  input  1  synchronous clear to zero.
- load  input  1  parallel load strobe.
- load_val  input  DW*DIGITS  load value; digit i in bits [DW*i +: DW], digit 0 is least significant.
- count  output  DW*DIGITS  current count, same packing as load_val.
- tc  output  1  terminal count, combinational, for cascading.
- ovf  output  1  one-cycle registered pulse on up-wrap.
- unf  output  1  one-cycle registered pulse on down-wrap.
- load_err  output  1  one-cycle registered pulse when a loaded digit was out of range.

Behaviour:
- Reset state: count = 0, ovf = 0, unf = 0, load_err = 0. tc follows its combinational definition from that state.
- Per-edge priority: reset > clear > load > en. Only the highest-priority active action takes effect.
- clear:
  - count <= 0.
  - ovf, unf and load_err are 0 on the following cycle.
- load:
  - Each digit is loaded from load_val.
  - Any digit >= MODULUS is clamped to MODULUS-1.
  - load_err = 1 on the next cycle if any digit was clamped, else 0.
  - en is ignored during a load cycle.
- en with up = 1 (increment):
  - digit 0 increments.
  - digit i steps only when digits 0..i-1 are all at MODULUS-1; those digits wrap to 0.
  - Carry ripple is combinational; all digits update on the same edge. Latency from the en edge to the new count is 1 cycle.
- en with up = 0 (decrement):
  - digit 0 decrements.
  - digit i steps only when digits 0..i-1 are all 0; those digits wrap to MODULUS-1.
- Whole-counter wrap:
  - Up from all-digits MODULUS-1 goes to all-zero. ovf = 1 in the same cycle that count shows all-zero, for exactly one cycle.
  - Down from all-zero goes to all-digits MODULUS-1, with unf asserted the same way.
- tc = en & ((up & all digits == MODULUS-1) | (~up & all digits == 0)).
  - tc ignores clear and load; it is a raw cascade signal. A downstream instance connects its en to the upstream tc.
- en = 0: count holds; ovf and unf are 0 on the next cycle.
- Changing direction mid-count needs no settling: the up value at the edge decides the step.
- Digit state is never >= MODULUS.
  - Illegal states are unreachable, since load clamps.
  - If one occurs anyway (SEU), the next enabled step treats the digit as MODULUS-1 during increment and wraps it to 0.
- Reset asserted mid-count, or at the same edge as load/clear/en: reset wins and all outputs take their reset values on that edge.
- Arithmetic is per-digit modulo, with no binary carry between digits. DW-bit compares against the constants MODULUS-1 and 0.

Decomposition:
- Shared package counter_pkg holds:
  - localparam DW = 4.
  - function digit_max(MODULUS) returning MODULUS-1.
  - the digit-packing index helper.
- One sub-module, mod_n_digit: a single digit with inputs step, up, load, load_digit, clear and outputs q, at_max, at_min, clamped.
- Top level generates DIGITS instances, builds the ripple-enable chain from at_max/at_min, and registers ovf, unf and load_err.

Test Plan:
- Reset: DIGITS=2, MODULUS=10, hold reset 2 cycles with en=1 -> count=0x00, ovf=unf=load_err=0 throughout.
- Up count with wrap: en=1, up=1 for 100 cycles from 0 -> count 00,01,...,09,10,...,99,00; ovf=1 only in the cycle count returns to 00; tc=1 only while count=99.
- Down count with wrap: load 0x00, en=1, up=0 -> next count=99 with unf=1 for one cycle, then 98, 97, ...
- Load clamp: load=1, load_val=0x3C (digit0=12, digit1=3) -> count=0x39, load_err=1 for exactly one cycle; the same load with en=1 also gives 0x39 (load beats en).
- Priority and holds: clear=1, load=1, en=1 simultaneously at count=0x57 -> count=0x00. en=0 for 5 cycles -> count holds. Reset pulse at count=0x42 -> 0x00.
- Cascade and MODULUS: two instances, DIGITS=1, MODULUS=6, second instance en = first tc, up=1 -> combined count runs 00..55, then 00; the second instance's ovf pulses once per 36 cycles.

Source files
------------

// File: rtl/bcd_updown_counter_pkg.sv
// Shared constants and helpers for the multi-digit modulo-N counter.
// Digits are DW bits wide and packed least-significant digit first.
package counter_pkg;

  localparam int DW = 4;

  localparam logic [DW-1:0] DIGIT_ZERO = 4'd0;
  localparam logic [DW-1:0] DIGIT_ONE  = 4'd1;

  function automatic logic [DW-1:0] digit_max(input int modulus);
    return DW'(modulus - 1);
  endfunction

  function automatic int digit_lsb(input int idx);
    return DW * idx;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control/status bundle of the up/down counter; the master drives the
// controls, the slave (the counter) returns count and the status pulses.
interface bcd_updown_counter_if
  import counter_pkg::*;
#(
  parameter int DIGITS = 4
) ();

  logic                  en;
  logic                  up;
  logic                  clear;
  logic                  load;
  logic [DW*DIGITS-1:0]  load_val;
  logic [DW*DIGITS-1:0]  count;
  logic                  tc;
  logic                  ovf;
  logic                  unf;
  logic                  load_err;

  modport master (
    output en, up, clear, load, load_val,
    input  count, tc, ovf, unf, load_err
  );

  modport slave (
    input  en, up, clear, load, load_val,
    output count, tc, ovf, unf, load_err
  );

endinterface

// File: rtl/bcd_updown_counter_digit.sv
// One modulo-MODULUS digit with clear, clamping load and a directional step.
// An out-of-range value behaves as the maximum so it leaves on the next step.
module mod_n_digit
  import counter_pkg::*;
#(
  parameter int MODULUS = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  input  logic          up,
  input  logic          load,
  input  logic [DW-1:0] load_digit,
  input  logic          clear,
  output logic [DW-1:0] q,
  output logic          at_max,
  output logic          at_min,
  output logic          clamped
);

  localparam logic [DW-1:0] MAX = digit_max(MODULUS);

  logic [DW-1:0] q_r;

  assign q       = q_r;
  assign at_max  = (q_r >= MAX);
  assign at_min  = (q_r == DIGIT_ZERO);
  assign clamped = (load_digit > MAX);

  // Digit register: reset > clear > load > step.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= DIGIT_ZERO;
    end else if (clear) begin
      q_r <= DIGIT_ZERO;
    end else if (load) begin
      q_r <= clamped ? MAX : load_digit;
    end else if (step) begin
      if (up) begin
        q_r <= at_max ? DIGIT_ZERO : (q_r + DIGIT_ONE);
      end else if (at_min) begin
        q_r <= MAX;
      end else if (q_r > MAX) begin
        q_r <= MAX;
      end else begin
        q_r <= q_r - DIGIT_ONE;
      end
    end else begin
      q_r <= q_r;
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// DIGITS-digit modulo-MODULUS up/down counter with combinational ripple
// enable, cascade terminal count and registered wrap/load-error pulses.
module bcd_updown_counter
  import counter_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int MODULUS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_updown_counter_if.slave   bus
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] clamped;
  logic [DIGITS-1:0] step;
  logic              all_term;
  logic              ovf_r;
  logic              unf_r;
  logic              load_err_r;

  // Ripple enable: a digit steps when every lower digit sits at its
  // terminal value for the current direction.
  always_comb begin
    logic run;
    run  = 1'b1;
    step = '0;
    for (int i = 0; i < DIGITS; i++) begin
      step[i] = bus.en & run;
      run     = run & (bus.up ? at_max[i] : at_min[i]);
    end
    all_term = run;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    mod_n_digit #(.MODULUS(MODULUS)) u_digit (
      .clk        (clk),
      .reset      (reset),
      .step       (step[g]),
      .up         (bus.up),
      .load       (bus.load),
      .load_digit (bus.load_val[digit_lsb(g) +: DW]),
      .clear      (bus.clear),
      .q          (bus.count[digit_lsb(g) +: DW]),
      .at_max     (at_max[g]),
      .at_min     (at_min[g]),
      .clamped    (clamped[g])
    );
  end

  // tc is a raw cascade signal and deliberately ignores clear/load.
  assign bus.tc       = bus.en & all_term;
  assign bus.ovf      = ovf_r;
  assign bus.unf      = unf_r;
  assign bus.load_err = load_err_r;

  // Status pulses land in the same cycle as the count they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
      load_err_r <= 1'b0;
    end else if (bus.clear) begin
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
      load_err_r <= 1'b0;
    end else if (bus.load) begin
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
      load_err_r <= |clamped;
    end else begin
      ovf_r      <= bus.en & bus.up & all_term;
      unf_r      <= bus.en & ~bus.up & all_term;
      load_err_r <= 1'b0;
    end
  end

endmodule
